// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: parity encodings, the TX/RX
// state type and the oversampling divider calculation.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } uartState_t;

    // Clocks per oversampling tick, truncated, never below one.
    function automatic int unsigned calcDiv(
        input int unsigned clkHz,
        input int unsigned baud,
        input int unsigned overSample
    );
        int unsigned d;
        d = clkHz / (baud * overSample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock oversampling tick shared by the
// transmitter and receiver.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV = calcDiv(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] WRAP = CW'(DIV - 1);

    logic [CW-1:0] divCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divCnt <= '0;
        end else if (divCnt == WRAP) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + CW'(1);
        end
    end

    assign tick = (divCnt == WRAP);

endmodule

// File: rtl/uart_transceiver_param.sv
// Single-clock UART transceiver: configurable data width, parity and stop bits,
// with a runtime loopback path from the transmitter into the receiver.
module uart_transceiver_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    input  logic                 serial_in,
    output logic                 serial_out,
    input  logic                 loopback
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] BIT_END  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] HALF_END = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic ODD       = (PARITY == PAR_ODD);
    localparam logic USE_PAR   = (PARITY != PAR_NONE);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    logic tick;

    uart_baud_tick #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) uBaudTick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // ---------------- transmitter ----------------
    uartState_t           txState, txStateNext;
    logic [DATA_BITS-1:0] txShift, txShiftNext;
    logic [TW-1:0]        txTicks, txTicksNext;
    logic [2:0]           txBits, txBitsNext;
    logic                 txStop, txStopNext;
    logic                 txPar, txParNext;
    logic                 txLine, txLineNext;
    logic                 txBitEnd;

    assign txBitEnd = tick && (txTicks == BIT_END);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txState <= IDLE;
            txShift <= '0;
            txTicks <= '0;
            txBits  <= '0;
            txStop  <= 1'b0;
            txPar   <= 1'b0;
            txLine  <= 1'b1;
        end else begin
            txState <= txStateNext;
            txShift <= txShiftNext;
            txTicks <= txTicksNext;
            txBits  <= txBitsNext;
            txStop  <= txStopNext;
            txPar   <= txParNext;
            txLine  <= txLineNext;
        end
    end

    always_comb begin
        txStateNext = txState;
        txShiftNext = txShift;
        txBitsNext  = txBits;
        txStopNext  = txStop;
        txParNext   = txPar;
        txTicksNext = tick ? txTicks + TW'(1) : txTicks;
        if (txBitEnd) txTicksNext = '0;
        case (txState)
            IDLE: begin
                txTicksNext = '0;
                if (tx_valid) begin
                    txStateNext = START;
                    txShiftNext = tx_data;
                    txParNext   = (^tx_data) ^ ODD;
                end
            end
            START: if (txBitEnd) begin
                txStateNext = DATA;
                txBitsNext  = '0;
            end
            DATA: if (txBitEnd) begin
                txShiftNext = txShift >> 1;
                txBitsNext  = txBits + 3'd1;
                txStopNext  = 1'b0;
                if (txBits == LAST_BIT) begin
                    if (USE_PAR) txStateNext = PAR;
                    else         txStateNext = STOP;
                end
            end
            PAR: if (txBitEnd) begin
                txStateNext = STOP;
                txStopNext  = 1'b0;
            end
            STOP: if (txBitEnd) begin
                if (txStop == STOP_LAST) txStateNext = IDLE;
                else                     txStopNext  = 1'b1;
            end
            default: txStateNext = IDLE;
        endcase
        // Line level decoded from the next state so the pin comes straight off a flop.
        case (txStateNext)
            START:   txLineNext = 1'b0;
            DATA:    txLineNext = txShiftNext[0];
            PAR:     txLineNext = txParNext;
            default: txLineNext = 1'b1;
        endcase
    end

    assign tx_ready   = (txState == IDLE);
    assign serial_out = txLine;

    // ---------------- receiver ----------------
    logic                 lineMux, sync1, sync2;
    uartState_t           rxState, rxStateNext;
    logic [DATA_BITS-1:0] rxShift, rxShiftNext;
    logic [TW-1:0]        rxTicks, rxTicksNext;
    logic [2:0]           rxBits, rxBitsNext;
    logic                 rxParBad, rxParBadNext;
    logic [DATA_BITS-1:0] rxDataNext;
    logic                 rxValidNext, rxParErrNext, rxFrameErrNext;
    logic                 rxBitEnd;

    assign lineMux  = loopback ? serial_out : serial_in;
    assign rxBitEnd = tick && (rxTicks == BIT_END);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            rxState       <= IDLE;
            rxShift       <= '0;
            rxTicks       <= '0;
            rxBits        <= '0;
            rxParBad      <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            sync1         <= lineMux;
            sync2         <= sync1;
            rxState       <= rxStateNext;
            rxShift       <= rxShiftNext;
            rxTicks       <= rxTicksNext;
            rxBits        <= rxBitsNext;
            rxParBad      <= rxParBadNext;
            rx_data       <= rxDataNext;
            rx_valid      <= rxValidNext;
            rx_parity_err <= rxParErrNext;
            rx_frame_err  <= rxFrameErrNext;
        end
    end

    always_comb begin
        rxStateNext    = rxState;
        rxShiftNext    = rxShift;
        rxBitsNext     = rxBits;
        rxParBadNext   = rxParBad;
        rxDataNext     = rx_data;
        rxValidNext    = 1'b0;
        rxParErrNext   = rx_parity_err;
        rxFrameErrNext = rx_frame_err;
        rxTicksNext    = tick ? rxTicks + TW'(1) : rxTicks;
        if (rxBitEnd) rxTicksNext = '0;
        case (rxState)
            IDLE: begin
                rxTicksNext = '0;
                if (!sync2) rxStateNext = START;
            end
            // Half-bit sample of the start bit puts every later sample mid-bit.
            START: if (tick && (rxTicks == HALF_END)) begin
                rxTicksNext = '0;
                rxBitsNext  = '0;
                if (sync2) rxStateNext = IDLE;
                else       rxStateNext = DATA;
            end
            DATA: if (rxBitEnd) begin
                rxShiftNext  = {sync2, rxShift[DATA_BITS-1:1]};
                rxBitsNext   = rxBits + 3'd1;
                rxParBadNext = 1'b0;
                if (rxBits == LAST_BIT) begin
                    if (USE_PAR) rxStateNext = PAR;
                    else         rxStateNext = STOP;
                end
            end
            PAR: if (rxBitEnd) begin
                rxParBadNext = sync2 ^ (^rxShift) ^ ODD;
                rxStateNext  = STOP;
            end
            STOP: if (rxBitEnd) begin
                rxDataNext     = rxShift;
                rxParErrNext   = rxParBad;
                rxFrameErrNext = ~sync2;
                rxValidNext    = 1'b1;
                rxStateNext    = IDLE;
            end
            default: rxStateNext = IDLE;
        endcase
    end

endmodule

// File: doc/uart_transceiver_param.md
Name: uart_transceiver_param

Overview:
Parametrised single-clock UART transceiver, successor to the fixed 8N1 transmit/receive pair.
- Derives its own oversampling tick from the system clock, so no external baud clocks are needed.
- Supports 5–8 data bits, none/even/odd parity, 1 or 2 stop bits, and a runtime loopback select.
- Sits between the processor/memory side (byte handshake) and the board serial pins.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s.
- OVERSAMPLE, 16, ticks per bit; must be even and at least 8.
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits transmitted: 1 or 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_BITS  byte to transmit.
- tx_valid  in  1  transmit request.
- tx_ready  out  1  transmitter idle; accepts tx_data this cycle.
- rx_data  out  DATA_BITS  last received word.
- rx_valid  out  1  one-cycle pulse: new rx_data and flags are valid.
- rx_parity_err  out  1  parity mismatch on the last received word.
- rx_frame_err  out  1  stop bit sampled low on the last received word.
- serial_in  in  1  external line input.
- serial_out  out  1  line output, idle high.
- loopback  in  1  1 = receiver listens to serial_out internally; 0 = receiver listens to serial_in.

Behaviour:
- Reset (rst = 0, asynchronous):
  - serial_out = 1, tx_ready = 1, rx_valid = 0, rx_data = 0, both error flags = 0.
  - Both FSMs go to IDLE; tick counter clears.
  - A reset mid-frame aborts the frame immediately, and the line returns high.
- Tick generator:
  - DIV = CLK_HZ / (BAUD*OVERSAMPLE), integer truncation, with a floor of 1.
  - Counter runs 0..DIV-1; `tick` is a one-cycle pulse on wrap.
  - One tick generator is shared by TX and RX.
- TX FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: tx_ready = 1. A cycle with tx_valid && tx_ready latches tx_data. tx_ready drops the next cycle; the state moves to START and the tick phase counter resets.
  - tx_valid while tx_ready = 0 is ignored; nothing is queued.
  - Each bit holds for exactly OVERSAMPLE ticks.
  - START drives 0.
  - DATA drives the data bits LSB first, DATA_BITS of them.
  - PAR drives the parity bit and is skipped when PARITY = 0. Even mode sends the XOR of the data bits; odd mode sends its complement.
  - STOP drives 1 for STOP_BITS bit times, then returns to IDLE; tx_ready = 1 in that same cycle.
  - Back-to-back requests therefore have no idle gap beyond the stop bits.
- RX path:
  - Input mux: line = loopback ? serial_out : serial_in.
  - The mux output passes through a 2-flop synchroniser, whose flops reset to 1.
- RX FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: waits for the synchronised line to go low, then enters START and clears the tick phase counter.
  - START: samples after OVERSAMPLE/2 ticks. If the line is high, this is a false start; return to IDLE with no rx_valid.
  - DATA: samples every OVERSAMPLE ticks and shifts bits in LSB first.
  - PAR: samples and compares against the expected parity; skipped when PARITY = 0, in which case rx_parity_err stays 0.
  - STOP: checks only the first stop bit; rx_frame_err = ~sample. Then:
    - rx_data and both flags update in the same cycle.
    - rx_valid pulses for 1 clk.
    - FSM returns to IDLE.
  - Output registers hold until the next completed frame. No back-pressure: a frame that is not consumed is overwritten.
  - A frame with a framing error still produces rx_valid.
- Toggling loopback mid-frame: the frame in progress is undefined. Operation after the next idle period is correct.
- Latency: in loopback, rx_valid asserts about (1 + DATA_BITS + P + 0.5) bit times + 3 clk after acceptance, where P = 1 if parity is on.

Decomposition:
- Package uart_pkg contains:
  - parity encoding constants: PAR_NONE = 0, PAR_EVEN = 1, PAR_ODD = 2;
  - TX/RX state enum (IDLE, START, DATA, PAR, STOP);
  - a function computing DIV.
- One sub-module, uart_baud_tick: parameters CLK_HZ, BAUD, OVERSAMPLE; ports clk, rst, tick.
- TX and RX stay as always-blocks in the top module.

Test Plan:
All tests use CLK_HZ = 1_600_000, BAUD = 10_000, OVERSAMPLE = 16, giving DIV = 10 and 160 clk per bit.

1. Reset: hold rst low for 5 clk while driving tx_valid = 1 → serial_out = 1, tx_ready = 1, rx_valid = 0 throughout. Release rst → one frame starts.
2. Loopback 8N1: send 0xA5 → serial_out shows 0,1,0,1,0,0,1,0,1,1, 160 clk each. tx_ready is low for 1600 clk. rx_valid pulses once with rx_data = 0xA5 and both errors 0.
3. PARITY = 1 (even), DATA_BITS = 7, external serial_in:
   - Drive 0x41 with parity bit 1 (wrong) → rx_data = 0x41, rx_parity_err = 1.
   - Resend with parity bit 0 → rx_parity_err = 0.
4. Framing error: drive 0x3C on serial_in with the stop bit low → rx_valid pulses with rx_data = 0x3C and rx_frame_err = 1.
5. False start and busy-ignore:
   - Glitch serial_in low for 40 clk → no rx_valid.
   - Assert tx_valid with 0x11 during an active transmission of 0x22 → only 0x22 is transmitted and received.
6. Mid-frame reset and back-to-back:
   - Assert rst after 500 clk of a frame → serial_out = 1 immediately, no rx_valid.
   - Then send 0x01 and 0xFF back-to-back with STOP_BITS = 2 → two rx_valid pulses, 0x01 then 0xFF, spaced 1760 clk apart.
